muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the iteration counter width; it SHALL satisfy 2^CNT_W > XLEN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: the execute stage presents a valid instruction.
REQ-006 The block SHALL have port op, input, 5 bits: the ALU operation code; MULHU=15, DIVU=16, REMU=17.
REQ-007 The block SHALL have port operand_a, input, XLEN bits: the multiplicand or dividend (unsigned).
REQ-008 The block SHALL have port operand_b, input, XLEN bits: the multiplier or divisor (unsigned).
REQ-009 The block SHALL have port flush, input, 1 bit: the pipeline kills the in-flight operation.
REQ-010 The block SHALL have port stall, output, 1 bit: holds the upstream pipeline stages.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in state BUSY.
REQ-012 The block SHALL have port result_valid, output, 1 bit: a one-cycle pulse marking result.
REQ-013 The block SHALL have port result, output, XLEN bits: the MULHU, DIVU or REMU result.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-015 An operation SHALL be accepted only when start=1, op is in {15,16,17}, flush=0 and the state is IDLE.
REQ-016 Any other op value, or start=0, SHALL leave the block in IDLE with no effect.
REQ-017 On accept, the block SHALL latch the op, the operands and a zeroed counter, then enter BUSY.
REQ-018 On accept, the exception is DIVU or REMU with operand_b=0, which SHALL go directly to DONE.
REQ-019 stall SHALL be combinational and equal to (accept condition) OR (state==BUSY).
REQ-020 stall SHALL be 0 in DONE, so the stage advances in the same cycle that result_valid is high.
REQ-021 BUSY SHALL perform exactly one iteration per cycle for XLEN cycles, then enter DONE.
REQ-022 The normal latency SHALL be XLEN+1 cycles from accept to result_valid, i.e. 33 cycles at XLEN=32.
REQ-023 MULHU SHALL use a shift-add over a 2*XLEN accumulator, and result SHALL be the upper XLEN bits of operand_a*operand_b.
REQ-024 DIVU and REMU SHALL use restoring division (remainder shift, trial subtract, quotient bit); DIVU SHALL return the quotient and REMU the remainder.
REQ-025 Divide-by-zero SHALL give DIVU = all ones and REMU = operand_a, with result_valid exactly 1 cycle after accept.
REQ-026 DONE SHALL last exactly one cycle with result_valid=1 and SHALL return unconditionally to IDLE.
REQ-027 A start in DONE SHALL be ignored.
REQ-028 result SHALL hold its last value until the next DONE.
REQ-029 start and operand changes while in BUSY SHALL be ignored, since the operands are latched.
REQ-030 flush in BUSY or DONE SHALL force IDLE on the next edge and suppress result_valid in that cycle.
REQ-031 When flush is high, stall SHALL be 0 in that same cycle.
REQ-032 flush in IDLE SHALL block acceptance in that cycle.
REQ-033 If flush and the final BUSY iteration coincide, flush SHALL win: no DONE and no result_valid.

Reset
REQ-034 When rst_n=0 at a clock edge, the state SHALL become IDLE and the counter 0.
REQ-035 Reset SHALL set result to 0, and result_valid, busy and stall to 0 from the next cycle.
REQ-036 Reset mid-operation SHALL discard the operation with no result_valid pulse.
REQ-037 Reset SHALL take priority over flush and start.

Structure
REQ-038 The op encodings (MULHU, DIVU, REMU) and the FSM state encodings SHALL live in a shared ALU package, which the function decoder SHALL also use.
REQ-039 One sub-module, muldiv_iter_step, SHALL be used: a combinational single iteration for both multiply and divide, selected by a mode bit.
REQ-040 The FSM, counter and operand registers SHALL stay in muldiv_sequencer.

Verification
REQ-041 The bench SHALL cover: MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE, result_valid at cycle 33, stall high in cycles 0-32.
REQ-042 The bench SHALL cover: DIVU 100/7 -> 14, and REMU 100/7 -> 2, each at cycle 33; a second DIVU issued in the DONE cycle is not accepted.
REQ-043 The bench SHALL cover: DIVU 0x1234/0 -> 0xFFFFFFFF, and REMU 0x1234/0 -> 0x1234, each with result_valid at cycle 1 and stall high only in cycle 0.
REQ-044 The bench SHALL cover: MULHU 0x80000000*4 with flush at cycle 10 -> IDLE at cycle 11, no result_valid, result unchanged.
REQ-045 The bench SHALL cover: rst_n low at cycle 20 of a DIVU -> busy=0 and result=0 next cycle, and no pulse after release.
REQ-046 The bench SHALL cover: start with op=ADD (0) or op=SLL (10) -> stall stays 0 and the state stays IDLE.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU definitions: operation codes, FSM states
// and the decoder helpers for the multi-cycle unit.
package muldiv_sequencer_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
    localparam logic [OP_W-1:0] OP_SLL   = 5'd10;
    localparam logic [OP_W-1:0] OP_MULHU = 5'd15;
    localparam logic [OP_W-1:0] OP_DIVU  = 5'd16;
    localparam logic [OP_W-1:0] OP_REMU  = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // True for any op handled by the multi-cycle unit.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // True for the divide family (quotient or remainder).
    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of shift-add multiply
// or restoring divide over a 2*XLEN accumulator.
module muldiv_iter_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              mode_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_sh;
    logic [XLEN:0] div_diff;
    logic          div_ok;

    // Multiply: acc = {partial, multiplier}; add b when the
    // multiplier LSB is set, then shift right with carry.
    // Divide: acc = {remainder, dividend/quotient}; shift
    // left, trial-subtract b, keep the difference if it fits.
    always_comb begin
        mul_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]}
                 + (acc_i[0] ? {1'b0, b_i} : '0);
        div_sh   = acc_i[2*XLEN-1:XLEN-1];
        div_diff = div_sh - {1'b0, b_i};
        div_ok   = ~div_diff[XLEN];
        if (mode_div_i) begin
            acc_o = {(div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                     acc_i[XLEN-2:0], div_ok};
        end else begin
            acc_o = {mul_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULHU/DIVU/REMU unit: IDLE/BUSY/DONE FSM,
// iteration counter and latched operands around one step.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    md_state_e         state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] step_acc;
    logic              accept;

    muldiv_iter_step #(
        .XLEN(XLEN)
    ) u_step (
        .mode_div_i(is_div(op_q)),
        .acc_i     (acc_q),
        .b_i       (b_q),
        .acc_o     (step_acc)
    );

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        accept   = start && is_muldiv(op) && !flush
                 && (state_q == ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op;
                    b_d   = operand_b;
                    cnt_d = '0;
                    acc_d = {{XLEN{1'b0}}, operand_a};
                    if (is_div(op) && (operand_b == '0)) begin
                        state_d  = ST_DONE;
                        result_d = (op == OP_DIVU) ? '1 : operand_a;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                        if (op_q == OP_DIVU) begin
                            result_d = step_acc[XLEN-1:0];
                        end else begin
                            result_d = step_acc[2*XLEN-1:XLEN];
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        stall        = !flush && (accept || (state_q == ST_BUSY));
        busy         = (state_q == ST_BUSY);
        result_valid = (state_q == ST_DONE) && !flush;
        result       = result_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner
// cases, flush/reset aborts and a short random sweep.
module tb_muldiv_sequencer;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SLL   = 5'd10;
    localparam logic [4:0] OP_MULHU = 5'd15;
    localparam logic [4:0] OP_DIVU  = 5'd16;
    localparam logic [4:0] OP_REMU  = 5'd17;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          t0;
        int          lat;
    } sb_t;

    sb_t sb[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;
    int  nvalid = 0;
    int  npush  = 0;

    muldiv_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (o == OP_MULHU) return p[63:32];
        if (o == OP_DIVU)  return (b == 0) ? 32'hFFFF_FFFF : a / b;
        return (b == 0) ? a : a % b;
    endfunction

    // Pop and compare each result pulse against the queue.
    always @(negedge clk) begin
        if (result_valid) begin
            nvalid++;
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_latency", cyc - e.t0, e.lat);
            end
        end
    end

    // Issue an op, check its stall profile and wait for DONE.
    task automatic run_op(input string tag, input logic [4:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        int bad;
        int n;
        int lat;
        @(posedge clk); #1;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        lat = ((o != OP_MULHU) && (b == 0)) ? 1 : 33;
        sb.push_back('{model(o, a, b), cyc, lat});
        npush++;
        bad = 0;
        @(negedge clk);
        if (stall !== 1'b1) bad++;
        @(posedge clk); #1;
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (result_valid === 1'b1 || n > 100) break;
            if (stall !== 1'b1) bad++;
        end
        chk({tag, "_done"}, (n <= 100), 1);
        chk({tag, "_stall_done"}, stall, 0);
        chk({tag, "_stall_busy"}, bad, 0);
    endtask

    // Accept an op that is not expected to complete.
    task automatic issue_nosb(input logic [4:0] o,
                              input logic [31:0] a,
                              input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  bad_ops [2];
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op = '0; operand_a = '0; operand_b = '0;
        bad_ops[0] = OP_ADD;
        bad_ops[1] = OP_SLL;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_result", result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
        start = 1'b1; op = OP_DIVU;
        operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_start_ignored", busy, 0);
        chk("done_start_stall", stall, 0);

        run_op("divu_by0", OP_DIVU, 32'h1234, 32'd0);
        run_op("remu_by0", OP_REMU, 32'h1234, 32'd0);

        issue_nosb(OP_MULHU, 32'h8000_0000, 32'd4);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall_low", stall, 0);
        chk("flush_valid_low", result_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", busy, 0);
        chk("flush_result_kept", result, 32'h1234);
        repeat (40) @(negedge clk);

        issue_nosb(OP_MULHU, 32'h8000_0000, 32'd4);
        repeat (31) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("lastflush_busy", busy, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("lastflush_no_valid", result_valid, 0);
        chk("lastflush_idle", busy, 0);
        chk("lastflush_result", result, 32'h1234);
        repeat (5) @(negedge clk);

        issue_nosb(OP_DIVU, 32'd1000, 32'd3);
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_stall", stall, 0);
        repeat (40) @(negedge clk);

        foreach (bad_ops[i]) begin
            @(posedge clk); #1;
            start = 1'b1; op = bad_ops[i];
            operand_a = 32'd5; operand_b = 32'd3;
            @(negedge clk);
            chk("badop_stall", stall, 0);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("badop_idle", busy, 0);
        end

        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = OP_DIVU;
        operand_a = 32'd9; operand_b = 32'd2;
        @(negedge clk);
        chk("idleflush_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idleflush_idle", busy, 0);
        chk("idleflush_valid", result_valid, 0);

        for (int k = 0; k < 6; k++) begin
            unique case (k % 3)
                0: ro = OP_MULHU;
                1: ro = OP_DIVU;
                default: ro = OP_REMU;
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0
                                             : ($urandom >> $urandom_range(0, 28));
            run_op("rand", ro, ra, rb);
        end

        repeat (5) @(negedge clk);
        chk("valid_count", nvalid, npush);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
